// File: rtl/i2f_pkg.sv
// Shared constants and types for the integer-to-float arbiter slice.
//   FLOAT_W / INT_W : converter result and operand widths
//   MAX_IDW         : widest requester tag supported (up to 16 requesters)
//   stage_t         : one pipeline stage record (valid, operand, requester tag)
package i2f_pkg;

    localparam int FLOAT_W = 32;
    localparam int INT_W   = 32;
    localparam int MAX_IDW = 4;

    typedef struct packed {
        logic               valid;
        logic [INT_W-1:0]   data;
        logic [MAX_IDW-1:0] id;
    } stage_t;

endpackage

// File: rtl/i2f.sv
// Combinational 32-bit signed integer to IEEE-754 single converter.
// Truncates (never rounds) and reports whether any magnitude bits were dropped.
//   d     : signed integer operand
//   f     : single-precision result (0 for d == 0)
//   plost : 1 when the mantissa could not hold every significant bit
module i2f
    import i2f_pkg::*;
(
    input  logic signed [INT_W-1:0]   d,
    output logic        [FLOAT_W-1:0] f,
    output logic                      plost
);

    logic        sign;
    logic [31:0] mag;
    logic [30:0] norm;
    logic [4:0]  msb;
    logic [7:0]  exp_f;

    always_comb begin
        sign = d[31];
        // Two's complement magnitude; 0x80000000 maps onto itself, which is
        // exactly 2^31 when read as unsigned.
        mag  = sign ? (~$unsigned(d) + 32'd1) : $unsigned(d);

        msb = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (mag[i]) begin
                msb = 5'(i);
            end
        end

        // Leading one moves to bit 31 and is dropped (hidden bit).
        norm  = 31'(mag << (5'd31 - msb));
        exp_f = 8'd127 + {3'b000, msb};

        f     = '0;
        plost = 1'b0;
        if (mag != '0) begin
            f     = {sign, exp_f, norm[30:8]};
            plost = |norm[7:0];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans from ptr+1 upward, wrapping, and grants the first active request.
//   req     : request vector
//   ptr     : index of the most recently served requester
//   grant   : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester
//   any     : at least one request is active
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/i2f_arbiter.sv
// Shares one integer-to-float converter among NREQ requesters.
// Round-robin grant into stage 1, converter between stage 1 and stage 2,
// stage 2 drives the tagged response. Full throughput with no bubbles.
//   clk, clrn     : clock, asynchronous active-low reset
//   req_valid/_ready/_data : per-requester valid/ready, 32 bits per requester
//   rsp_valid/_ready       : response handshake
//   rsp_data, rsp_plost, rsp_id : float result, precision-lost flag, source tag
//   plost_cnt     : saturating count of accepted responses with rsp_plost=1
module i2f_arbiter
    import i2f_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int CNTW = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*INT_W-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [FLOAT_W-1:0]      rsp_data,
    output logic                    rsp_plost,
    output logic [IDW-1:0]          rsp_id,
    output logic [CNTW-1:0]         plost_cnt
);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [IDW-1:0]     ptr_q, ptr_d;
    stage_t             s1_q, s1_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [FLOAT_W-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_plost_q, rsp_plost_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [CNTW-1:0]    plost_cnt_q, plost_cnt_d;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gnt_idx;
    logic               any_req;
    logic [FLOAT_W-1:0] conv_f;
    logic               conv_plost;
    logic               adv2, s1_free, granted;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    i2f u_i2f (
        .d     (s1_q.data),
        .f     (conv_f),
        .plost (conv_plost)
    );

    always_comb begin
        adv2    = s1_q.valid && (!rsp_valid_q || rsp_ready);
        s1_free = !s1_q.valid || adv2;
        // Gating with clrn keeps req_ready low for the whole reset pulse,
        // not just from the next edge.
        granted   = clrn && any_req && s1_free;
        req_ready = granted ? grant : '0;

        ptr_d       = ptr_q;
        s1_d        = s1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_plost_d = rsp_plost_q;
        rsp_id_d    = rsp_id_q;
        plost_cnt_d = plost_cnt_q;

        // Stage 1: the pointer only moves on a real transfer.
        if (granted) begin
            ptr_d      = gnt_idx;
            s1_d.valid = 1'b1;
            s1_d.data  = req_data[int'(gnt_idx)*INT_W +: INT_W];
            s1_d.id    = MAX_IDW'(gnt_idx);
        end else if (adv2) begin
            s1_d.valid = 1'b0;
        end

        // Stage 2: converter output captured only when stage 1 advances.
        rsp_valid_d = adv2 ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        if (adv2) begin
            rsp_data_d  = conv_f;
            rsp_plost_d = conv_plost;
            rsp_id_d    = IDW'(s1_q.id);
        end

        if (rsp_valid_q && rsp_ready && rsp_plost_q) begin
            plost_cnt_d = sat_inc(plost_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ptr_q       <= IDW'(NREQ - 1);
            s1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_plost_q <= 1'b0;
            rsp_id_q    <= '0;
            plost_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_q        <= s1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_plost_q <= rsp_plost_d;
            rsp_id_q    <= rsp_id_d;
            plost_cnt_q <= plost_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_plost = rsp_plost_q;
    assign rsp_id    = rsp_id_q;
    assign plost_cnt = plost_cnt_q;

endmodule

// File: tb/tb_i2f_arbiter.sv
// Scoreboard bench for i2f_arbiter: accepted requests push hand-computed
// expected results, a negedge monitor pops and compares on each response.
module tb_i2f_arbiter;

    localparam int NREQ = 4;
    localparam int CNTW = 16;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 clrn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_plost;
    logic [IDW-1:0]       rsp_id;
    logic [CNTW-1:0]      plost_cnt;

    i2f_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_plost (rsp_plost),
        .rsp_id    (rsp_id),
        .plost_cnt (plost_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [31:0] f; logic pl; } item_t;
    typedef struct { logic [31:0] f; logic pl; int id; int acc_cyc; } exp_t;

    item_t           sq [NREQ][$];
    exp_t            eq [$];
    int              cyc = 0;
    int              n_pass = 0;
    int              n_tot = 0;
    int              ptr_m;
    int              first_acc;
    int              first_id;
    int              last_rsp;
    logic [CNTW-1:0] cnt_m;
    bit              chk_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push(input int r, input logic [31:0] d, input logic [31:0] f, input logic pl);
        item_t it;
        it.d = d; it.f = f; it.pl = pl;
        sq[r].push_back(it);
    endtask

    function automatic int rr_win(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit busy();
        if (eq.size() != 0) return 1'b1;
        for (int i = 0; i < NREQ; i++) if (sq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (busy()) begin
            n_tot++;
            $display("FAIL drain_timeout: %0d items still pending after %0d cycles", eq.size(), budget);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: present the head of each requester's queue, held until popped.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (sq[i].size() != 0) begin
                req_valid[i]         = 1'b1;
                req_data[32*i +: 32] = sq[i][0].d;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Monitor: decides what the next rising edge transfers.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] er;
        int              w;
        exp_t            e;
        item_t           it;
        if (clrn) begin
            chk("plost_cnt_track", plost_cnt, cnt_m);
            chk("occupancy_le_2", 32'(eq.size() <= 2), 32'd1);

            w  = rr_win(req_valid, ptr_m);
            er = '0;
            if (w >= 0 && (eq.size() < 2 || rsp_ready)) er[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));

            if (rsp_valid && rsp_ready) begin
                if (eq.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_rsp: got data 0x%0h id %0d, required no response", rsp_data, rsp_id);
                end else begin
                    e = eq.pop_front();
                    chk("rsp_data", rsp_data, e.f);
                    chk("rsp_plost", 32'(rsp_plost), 32'(e.pl));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    if (chk_lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                    if (e.pl && cnt_m != '1) cnt_m = cnt_m + 1'b1;
                    last_rsp = cyc;
                end
            end

            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i] && sq[i].size() != 0) begin
                    it = sq[i].pop_front();
                    e.f = it.f; e.pl = it.pl; e.id = i; e.acc_cyc = cyc;
                    eq.push_back(e);
                    ptr_m = i;
                    if (first_acc < 0) first_acc = cyc;
                    if (first_id < 0) first_id = i;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        clrn = 1'b0; rsp_ready = 1'b1; req_valid = '0; req_data = '0;
        ptr_m = NREQ - 1; cnt_m = '0; first_acc = -1; first_id = -1; last_rsp = 0;
        chk_lat = 1'b1;

        // Reset state, with requests pending to prove req_ready stays low.
        #2; req_valid = '1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_plost", 32'(rsp_plost), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_plost_cnt", 32'(plost_cnt), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #3 clrn = 1'b1;

        // Simple values from requester 0.
        push(0, 32'd1,         32'h3F800000, 1'b0);
        push(0, 32'hFFFFFFFF,  32'hBF800000, 1'b0);
        push(0, 32'd0,         32'h00000000, 1'b0);
        drain(50);

        // Truncation and extreme values from requester 2.
        push(2, 32'h01000001, 32'h4B800000, 1'b1);
        push(2, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1);
        push(2, 32'h80000000, 32'hCF000000, 1'b0);
        drain(50);
        @(negedge clk);
        chk("plost_cnt_after_t2", 32'(plost_cnt), 32'd2);

        // All four requesters contend; one result per cycle.
        @(posedge clk);
        first_acc = -1;
        push(0, 32'd1,   32'h3F800000, 1'b0); push(0, 32'd2,   32'h40000000, 1'b0); push(0, 32'd3,  32'h40400000, 1'b0);
        push(1, 32'd4,   32'h40800000, 1'b0); push(1, 32'd5,   32'h40A00000, 1'b0); push(1, 32'd6,  32'h40C00000, 1'b0);
        push(2, 32'd7,   32'h40E00000, 1'b0); push(2, 32'd8,   32'h41000000, 1'b0); push(2, 32'hFFFFFFFE, 32'hC0000000, 1'b0);
        push(3, 32'd10,  32'h41200000, 1'b0); push(3, 32'd16,  32'h41800000, 1'b0); push(3, 32'd100, 32'h42C80000, 1'b0);
        drain(100);
        @(negedge clk);
        chk("burst_span", 32'(last_rsp - first_acc), 32'd13);

        // Back-pressure in the middle of a burst.
        chk_lat = 1'b0;
        @(posedge clk);
        push(1, 32'h00FFFFFF, 32'h4B7FFFFF, 1'b0);
        push(1, 32'h01000003, 32'h4B800001, 1'b1);
        push(1, 32'hFFFFFFFF, 32'hBF800000, 1'b0);
        push(1, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1);
        push(3, 32'd2,        32'h40000000, 1'b0);
        push(3, 32'h80000000, 32'hCF000000, 1'b0);
        repeat (2) @(posedge clk);
        #2 rsp_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("stall_held", 32'(eq.size()), 32'd2);
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        drain(100);
        @(negedge clk);
        chk("plost_cnt_after_t4", 32'(plost_cnt), 32'd4);

        // Asynchronous reset with both stages full.
        rsp_ready = 1'b0;
        push(0, 32'd5, 32'h40A00000, 1'b0);
        push(0, 32'd6, 32'h40C00000, 1'b0);
        push(0, 32'd7, 32'h40E00000, 1'b0);
        repeat (4) @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_plost_cnt", 32'(plost_cnt), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < NREQ; i++) sq[i].delete();
        eq.delete();
        ptr_m = NREQ - 1; cnt_m = '0;
        repeat (2) @(posedge clk);
        #3 clrn = 1'b1;
        rsp_ready = 1'b1;
        first_id = -1;
        push(1, 32'd16,  32'h41800000, 1'b0);
        push(3, 32'd100, 32'h42C80000, 1'b0);
        push(0, 32'd8,   32'h41000000, 1'b0);
        drain(50);
        chk("first_after_reset", 32'(first_id), 32'd0);

        // Saturation of the precision-lost counter.
        @(negedge clk);
        #2;
        cnt_m = 16'hFFFE;
        force dut.plost_cnt_q = 16'hFFFE;
        #1 release dut.plost_cnt_q;
        for (int k = 0; k < 3; k++) push(0, 32'h01000001, 32'h4B800000, 1'b1);
        drain(50);
        @(negedge clk);
        chk("plost_cnt_sat", 32'(plost_cnt), 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/i2f_arbiter.md
Name: i2f_arbiter

Overview:
- Shares one integer-to-float converter (the existing combinational i2f: 32-bit signed integer in, IEEE-754 single out, truncating, with a precision-lost flag) among NREQ requesters.
- Round-robin arbitration, a two-stage valid/ready pipeline around the converter, and responses tagged with the requester ID.
- Sits between integer-producing clients and the float datapath, one conversion per cycle at full throughput.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), ID/tag width; derived, never overridden.
- CNTW, 16, width of the saturating precision-lost counter.

Ports:
- clk  in  1  clock.
- clrn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*32  per-requester integer; requester i occupies bits [32*i+31:32*i].
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  32  float result.
- rsp_plost  out  1  precision lost for this result.
- rsp_id  out  IDW  index of the originating requester.
- plost_cnt  out  CNTW  count of accepted responses with rsp_plost=1, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is clrn, asynchronous and active-low.
- Reset state: s1_valid=0, rsp_valid=0, rsp_data/rsp_plost/rsp_id=0, plost_cnt=0, rr pointer=NREQ-1 (requester 0 has first priority). req_ready=0 while clrn is low.
- Reset asserted mid-operation discards all in-flight items; no response is produced for them.
- Handshakes: a transfer occurs when valid&&ready on the same rising edge. Requesters hold req_valid and req_data stable until accepted. Downstream holds rsp_* stable while rsp_valid&&!rsp_ready.
- Stage 1 (s1_valid, s1_data, s1_id) register; the i2f converter is combinational between s1 and stage 2; stage 2 (rsp_*) register.
- Stage 2 advance condition: adv2 = s1_valid && (!rsp_valid || rsp_ready).
- Stage 1 accept condition: s1_free = !s1_valid || adv2.
- Arbitration (combinational): scan requesters from ptr+1 upward, wrapping modulo NREQ; the first with req_valid=1 is the winner. req_ready[winner]=s1_free; all other req_ready bits are 0.
- On grant: s1 loads the winner's data and ID, and ptr becomes the winner's index. ptr changes only on an actual transfer, never on a stalled grant.
- s1_valid next = granted ? 1 : (adv2 ? 0 : s1_valid).
- rsp_valid next = adv2 ? 1 : (rsp_ready ? 0 : rsp_valid). rsp_data, rsp_plost and rsp_id load only on adv2.
- Latency: a grant at edge N gives rsp_valid high after edge N+1. With rsp_ready held at 1, throughput is one result per cycle with no bubbles.
- Back-pressure: rsp_ready=0 with both stages full gives s1_free=0, so all req_ready are 0 and no data is lost or duplicated. Release restarts flow on the next edge.
- Simultaneous events: a response transfer and an s1-to-s2 advance on the same edge is legal. An s1 drain and a new grant on the same edge is legal.
- Converter results: d=0 gives 0x00000000 with plost=0. Truncation only, no rounding. 0x80000000 gives 0xCF000000.
- plost_cnt: increments on rsp_valid&&rsp_ready&&rsp_plost. It holds at 2^CNTW-1 and never wraps.
- Fairness: under continuous requests from all requesters, each is granted exactly once per NREQ grants.

Decomposition:
- Package i2f_pkg: constants FLOAT_W=32, INT_W=32; a typedef for the stage record (valid, data, id).
- Sub-module: the existing i2f is instantiated once. rr_arbiter (request vector plus pointer in, one-hot grant out) is a separate natural sub-module.
- Everything else stays in i2f_arbiter.

Test Plan:
- Single requester 0 sends d=1, then d=-1, then d=0, rsp_ready=1 -> 0x3F800000, 0xBF800000, 0x00000000. plost=0, id=0, each 2 cycles after accept.
- Requester 2 sends 0x01000001, 0x7FFFFFFF, 0x80000000 -> 0x4B800000/plost=1, 0x4EFFFFFF/plost=1, 0xCF000000/plost=0. plost_cnt ends at 2.
- All 4 requesters hold valid for 12 cycles with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3...; one result per cycle; each request accepted exactly once.
- rsp_ready=0 for 5 cycles during a burst -> at most 2 items held; req_ready all 0 after both stages fill; output order and values intact after release.
- Assert clrn low with both stages full -> rsp_valid=0 and plost_cnt=0 immediately (asynchronously). Next grant after release goes to requester 0.
- Force plost_cnt to 0xFFFE and deliver 3 plost results -> count saturates at 0xFFFF.
